// File: rtl/seq_bram_arbiter.sv
// Arbitrates the single-port sequence BRAM between the micro_sequencer fetch port and
// the host load/readback port, returning read data to its owner through a tag pipeline.
module seq_bram_arbiter #(
    parameter int BRAM_DATA_WIDTH = 64,
    parameter int BRAM_ADDR_WIDTH = 13,
    parameter int READ_LATENCY    = 2,
    parameter int HOST_MAX_WAIT   = 8
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESETN,
    input  logic                       seq_running,
    input  logic                       seq_req,
    input  logic [BRAM_ADDR_WIDTH-1:0] seq_addr,
    output logic                       seq_gnt,
    output logic                       seq_rdvalid,
    output logic [BRAM_DATA_WIDTH-1:0] seq_rddata,
    input  logic                       host_req,
    input  logic                       host_we,
    input  logic [BRAM_ADDR_WIDTH-1:0] host_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] host_wrdata,
    output logic                       host_gnt,
    output logic                       host_rdvalid,
    output logic [BRAM_DATA_WIDTH-1:0] host_rddata,
    output logic                       bram_en,
    output logic                       bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_wrdata,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_rddata,
    output logic [7:0]                 host_wait_max
);

    localparam logic [7:0] MAX_WAIT = 8'(HOST_MAX_WAIT);

    // Handshake: a requester raises *_req with stable fields and holds it until it sees
    // *_gnt high in the same cycle; req&gnt at a rising edge is the single transfer point.
    logic [7:0]            wait_cnt;
    logic [READ_LATENCY:0] tag_vld;
    logic [READ_LATENCY:0] tag_host;
    logic                  issue_rd;

    always_comb begin
        host_gnt = S_AXI_ARESETN & host_req &
                   (!seq_req | !seq_running | (wait_cnt >= MAX_WAIT));
        seq_gnt  = S_AXI_ARESETN & seq_req & !host_gnt;
        issue_rd = seq_gnt | (host_gnt & !host_we);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            bram_en     <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_wrdata <= '0;
        end else begin
            bram_en <= seq_gnt | host_gnt;
            bram_we <= host_gnt & host_we;
            if (host_gnt) begin
                bram_addr   <= host_addr;
                bram_wrdata <= host_wrdata;
            end else if (seq_gnt) begin
                bram_addr   <= seq_addr;
            end
        end
    end

    // Stage k of the tag pipe lines up with the BRAM access k+1 cycles after the grant.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            tag_vld  <= '0;
            tag_host <= '0;
        end else begin
            tag_vld  <= {tag_vld[READ_LATENCY-1:0], issue_rd};
            tag_host <= {tag_host[READ_LATENCY-1:0], host_gnt};
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            seq_rdvalid  <= 1'b0;
            host_rdvalid <= 1'b0;
            seq_rddata   <= '0;
            host_rddata  <= '0;
        end else begin
            seq_rdvalid  <= tag_vld[READ_LATENCY] & !tag_host[READ_LATENCY];
            host_rdvalid <= tag_vld[READ_LATENCY] & tag_host[READ_LATENCY];
            if (tag_vld[READ_LATENCY] & !tag_host[READ_LATENCY]) begin
                seq_rddata <= bram_rddata;
            end
            if (tag_vld[READ_LATENCY] & tag_host[READ_LATENCY]) begin
                host_rddata <= bram_rddata;
            end
        end
    end

    // Starvation tracking: counts consecutive refused host cycles, saturating at 255.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wait_cnt      <= '0;
            host_wait_max <= '0;
        end else begin
            if (host_req & !host_gnt) begin
                wait_cnt <= (wait_cnt == 8'hff) ? wait_cnt : wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (wait_cnt > host_wait_max) begin
                host_wait_max <= wait_cnt;
            end
        end
    end

endmodule

// File: tb/tb_seq_bram_arbiter.sv
// Directed bench for seq_bram_arbiter: u_dut runs with HOST_MAX_WAIT=8, u_dut1 with
// HOST_MAX_WAIT=1 for the interleaving case; each has a write-first BRAM model.
module tb_seq_bram_arbiter;

    localparam int DW = 64;
    localparam int AW = 13;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          seq_running, seq_req, seq_gnt, seq_rdvalid;
    logic [AW-1:0] seq_addr;
    logic [DW-1:0] seq_rddata;
    logic          host_req, host_we, host_gnt, host_rdvalid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wrdata, host_rddata;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wrdata, bram_rddata;
    logic [7:0]    host_wait_max;

    logic          seq_req_1, seq_gnt_1, seq_rdvalid_1;
    logic [AW-1:0] seq_addr_1;
    logic [DW-1:0] seq_rddata_1;
    logic          host_req_1, host_gnt_1, host_rdvalid_1;
    logic [AW-1:0] host_addr_1;
    logic [DW-1:0] host_rddata_1;
    logic          bram_en_1, bram_we_1;
    logic [AW-1:0] bram_addr_1;
    logic [DW-1:0] bram_wrdata_1, bram_rddata_1;
    logic [7:0]    host_wait_max_1;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] p0, p1, p0_1, p1_1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int seq_rv_cnt = 0;
    int host_rv_cnt = 0;

    logic [DW-1:0] seq_exp_q[$];
    int            seq_due_q[$];
    logic [DW-1:0] host_exp_q[$];
    int            host_due_q[$];

    int t_saddr[10] = '{400, 401, 401, 402, 402, 0, 0, 0, 0, 0};
    int t_haddr[10] = '{500, 500, 501, 501, 0, 0, 0, 0, 0, 0};

    seq_bram_arbiter #(.BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW),
                       .READ_LATENCY(RL), .HOST_MAX_WAIT(8)) u_dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .seq_running(seq_running),
        .seq_req(seq_req), .seq_addr(seq_addr), .seq_gnt(seq_gnt),
        .seq_rdvalid(seq_rdvalid), .seq_rddata(seq_rddata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wrdata(host_wrdata), .host_gnt(host_gnt), .host_rdvalid(host_rdvalid),
        .host_rddata(host_rddata), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata),
        .host_wait_max(host_wait_max)
    );

    seq_bram_arbiter #(.BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW),
                       .READ_LATENCY(RL), .HOST_MAX_WAIT(1)) u_dut1 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .seq_running(1'b1),
        .seq_req(seq_req_1), .seq_addr(seq_addr_1), .seq_gnt(seq_gnt_1),
        .seq_rdvalid(seq_rdvalid_1), .seq_rddata(seq_rddata_1),
        .host_req(host_req_1), .host_we(1'b0), .host_addr(host_addr_1),
        .host_wrdata('0), .host_gnt(host_gnt_1), .host_rdvalid(host_rdvalid_1),
        .host_rddata(host_rddata_1), .bram_en(bram_en_1), .bram_we(bram_we_1),
        .bram_addr(bram_addr_1), .bram_wrdata(bram_wrdata_1), .bram_rddata(bram_rddata_1),
        .host_wait_max(host_wait_max_1)
    );

    function automatic logic [DW-1:0] pat(input int a);
        return {32'hC0DE0000 + 32'(a), ~32'(a)};
    endfunction

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // write-first BRAM models, READ_LATENCY=2 from the registered pins
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] = bram_wrdata;
            p0 <= mem[bram_addr];
        end
        p1 <= p0;
        if (bram_en_1) p0_1 <= pat(int'(bram_addr_1));
        p1_1 <= p0_1;
    end
    assign bram_rddata   = p1;
    assign bram_rddata_1 = p1_1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // driver: inputs change 1ns after the edge, outputs are sampled 1ns later
    task automatic drive(input logic rn, input logic sr, input int sa, input logic hr,
                         input logic hwe, input int ha, input logic [DW-1:0] hwd);
        @(posedge clk);
        #1;
        rst_n = rn; seq_req = sr; seq_addr = AW'(sa);
        host_req = hr; host_we = hwe; host_addr = AW'(ha); host_wrdata = hwd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic push_seq(input logic [DW-1:0] d);
        seq_exp_q.push_back(d);
        seq_due_q.push_back(cyc + RL + 2);
    endtask

    task automatic push_host(input logic [DW-1:0] d);
        host_exp_q.push_back(d);
        host_due_q.push_back(cyc + RL + 2);
    endtask

    // scoreboard for u_dut returns: owner, data and exact return cycle
    always @(negedge clk) begin
        if (seq_rdvalid === 1'b1) begin
            seq_rv_cnt++;
            if (seq_exp_q.size() == 0) check("seq_rdvalid_unexpected", 1, 0);
            else begin
                check("seq_rd_cycle", 64'(cyc), 64'(seq_due_q.pop_front()));
                check("seq_rddata", seq_rddata, seq_exp_q.pop_front());
            end
        end else if (seq_due_q.size() > 0 && seq_due_q[0] <= cyc) begin
            check("seq_rdvalid_missing", 0, 1);
            void'(seq_due_q.pop_front());
            void'(seq_exp_q.pop_front());
        end
        if (host_rdvalid === 1'b1) begin
            host_rv_cnt++;
            if (host_exp_q.size() == 0) check("host_rdvalid_unexpected", 1, 0);
            else begin
                check("host_rd_cycle", 64'(cyc), 64'(host_due_q.pop_front()));
                check("host_rddata", host_rddata, host_exp_q.pop_front());
            end
        end else if (host_due_q.size() > 0 && host_due_q[0] <= cyc) begin
            check("host_rdvalid_missing", 0, 1);
            void'(host_due_q.pop_front());
            void'(host_exp_q.pop_front());
        end
    end

    initial begin
        int sa;
        int rv_base;
        logic exp_h;
        logic [DW-1:0] wd;
        for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i);
        rst_n = 1'b0; seq_running = 1'b1; seq_req = 1'b0; seq_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wrdata = '0;
        seq_req_1 = 1'b0; seq_addr_1 = '0; host_req_1 = 1'b0; host_addr_1 = '0;

        // reset: grants forced low even with both requesting
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 3, 1'b1, 1'b1, 4, 64'h1234);
            check("rst_seq_gnt", 64'(seq_gnt), 0);
            check("rst_host_gnt", 64'(host_gnt), 0);
        end
        check("rst_bram_en", 64'(bram_en), 0);
        check("rst_bram_we", 64'(bram_we), 0);
        check("rst_bram_addr", 64'(bram_addr), 0);
        check("rst_bram_wrdata", bram_wrdata, 0);
        check("rst_seq_rdvalid", 64'(seq_rdvalid), 0);
        check("rst_host_rdvalid", 64'(host_rdvalid), 0);
        check("rst_seq_rddata", seq_rddata, 0);
        check("rst_host_rddata", host_rddata, 0);
        check("rst_wait_max", 64'(host_wait_max), 0);
        idle(2);

        // 1: streaming sequencer fetch
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, i, 1'b0, 1'b0, 0, '0);
            check("t1_seq_gnt", 64'(seq_gnt), 1);
            check("t1_host_gnt", 64'(host_gnt), 0);
            if (i > 0) begin
                check("t1_bram_en", 64'(bram_en), 1);
                check("t1_bram_addr", 64'(bram_addr), 64'(i - 1));
            end
            push_seq(pat(i));
        end
        idle(1);
        check("t1_bram_en_idle", 64'(bram_en), 1);
        idle(1);
        check("t1_bram_en_off", 64'(bram_en), 0);
        check("t1_bram_addr_hold", 64'(bram_addr), 5);
        idle(5);

        // 2: host write then read-back of addr 5, sequencer halted
        seq_running = 1'b0;
        wd = 64'hDEADBEEF_00000001;
        drive(1'b1, 1'b0, 0, 1'b1, 1'b1, 5, wd);
        check("t2_wr_host_gnt", 64'(host_gnt), 1);
        drive(1'b1, 1'b0, 0, 1'b1, 1'b0, 5, '0);
        check("t2_rd_host_gnt", 64'(host_gnt), 1);
        check("t2_bram_we", 64'(bram_we), 1);
        check("t2_bram_addr", 64'(bram_addr), 5);
        check("t2_bram_wrdata", bram_wrdata, wd);
        push_host(wd);
        idle(1);
        check("t2_bram_we_read", 64'(bram_we), 0);
        idle(6);

        // 3: host starves until wait_cnt reaches 8, then pre-empts one slot
        seq_running = 1'b1;
        sa = 100;
        for (int k = 1; k <= 11; k++) begin
            drive(1'b1, 1'b1, sa, (k <= 9), 1'b0, 7, '0);
            exp_h = (k == 9);
            check("t3_host_gnt", 64'(host_gnt), 64'(exp_h));
            check("t3_seq_gnt", 64'(seq_gnt), 64'(!exp_h));
            if (exp_h) push_host(pat(7));
            else begin
                push_seq(pat(sa));
                sa++;
            end
        end
        idle(7);
        check("t3_wait_max", 64'(host_wait_max), 8);

        // 4: same-cycle requests with sequencer halted
        seq_running = 1'b0;
        drive(1'b1, 1'b1, 200, 1'b1, 1'b0, 9, '0);
        check("t4_host_gnt", 64'(host_gnt), 1);
        check("t4_seq_gnt", 64'(seq_gnt), 0);
        push_host(pat(9));
        drive(1'b1, 1'b1, 200, 1'b0, 1'b0, 0, '0);
        check("t4_seq_gnt_next", 64'(seq_gnt), 1);
        push_seq(pat(200));
        idle(7);

        // 5: reset one cycle after three back-to-back grants drops them all
        seq_running = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 300 + i, 1'b0, 1'b0, 0, '0);
            check("t5_seq_gnt", 64'(seq_gnt), 1);
        end
        rv_base = seq_rv_cnt + host_rv_cnt;
        drive(1'b0, 1'b1, 303, 1'b0, 1'b0, 0, '0);
        check("t5_gnt_forced", 64'(seq_gnt), 0);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, '0);
        check("t5_bram_en", 64'(bram_en), 0);
        check("t5_wait_max", 64'(host_wait_max), 0);
        idle(8);
        check("t5_no_rdvalid", 64'(seq_rv_cnt + host_rv_cnt - rv_base), 0);

        // 6: HOST_MAX_WAIT=1 alternates seq, host, seq, host
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            seq_req_1 = (j <= 4); seq_addr_1 = AW'(t_saddr[j]);
            host_req_1 = (j <= 3); host_addr_1 = AW'(t_haddr[j]);
            #1;
            check("t6_seq_gnt", 64'(seq_gnt_1), 64'(j == 0 || j == 2 || j == 4));
            check("t6_host_gnt", 64'(host_gnt_1), 64'(j == 1 || j == 3));
            check("t6_seq_rdvalid", 64'(seq_rdvalid_1), 64'(j == 4 || j == 6 || j == 8));
            check("t6_host_rdvalid", 64'(host_rdvalid_1), 64'(j == 5 || j == 7));
            if (j == 4 || j == 6 || j == 8) check("t6_seq_rddata", seq_rddata_1, pat(400 + (j - 4) / 2));
            if (j == 5 || j == 7) check("t6_host_rddata", host_rddata_1, pat(500 + (j - 5) / 2));
            if (j == 6) check("t6_host_rddata_hold", host_rddata_1, pat(500));
        end

        check("end_seq_q_empty", 64'(seq_exp_q.size()), 0);
        check("end_host_q_empty", 64'(host_exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
